// File: rtl/vga_ctrl.sv
// rtl/vga_ctrl.sv - VGA 640x480@60 timing generator, pixel request/blanking stage and per-frame shadows
//
// Purpose: free-running horizontal/vertical counters decode sync, active-area and
// pixel-request windows. pix_x/pix_y are issued one clock ahead of display so a
// registered pixel generator's pix_data lines up with rgb_valid. status/num are
// sampled once per frame so the picture never changes mid-frame.
//
// Ports:
//   vga_clk      pixel clock (25 MHz)
//   sys_rst_n    asynchronous active-low reset
//   pix_data     RGB444 returned by the pixel generator (registered there)
//   status_in    live key status          num_in   live song select
//   pix_x/pix_y  requested column/row, 10'h3FF when no request
//   status/num   frame-synchronous shadows of status_in/num_in
//   hsync/vsync  sync outputs, active level SYNC_POL
//   rgb          colour pins, forced black outside the active area
//   rgb_valid    active-area flag
//   frame_start  one-clock pulse at cnt_h == 0, cnt_v == 0 (not after reset)
module vga_ctrl #(
  parameter int   H_SYNC   = 96,
  parameter int   H_BACK   = 48,
  parameter int   H_VALID  = 640,
  parameter int   H_FRONT  = 16,
  parameter int   V_SYNC   = 2,
  parameter int   V_BACK   = 33,
  parameter int   V_VALID  = 480,
  parameter int   V_FRONT  = 10,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [11:0] pix_data,
  input  logic [6:0]  status_in,
  input  logic [3:0]  num_in,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [6:0]  status,
  output logic [3:0]  num,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        rgb_valid,
  output logic        frame_start
);

  localparam logic [9:0] H_LAST    = 10'(H_SYNC + H_BACK + H_VALID + H_FRONT - 1);
  localparam logic [9:0] V_LAST    = 10'(V_SYNC + V_BACK + V_VALID + V_FRONT - 1);
  localparam logic [9:0] H_SYNC_W  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W  = 10'(V_SYNC);
  localparam logic [9:0] H_START   = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_END     = 10'(H_SYNC + H_BACK + H_VALID);
  localparam logic [9:0] H_REQ_BEG = 10'(H_SYNC + H_BACK - 1);
  localparam logic [9:0] H_REQ_END = 10'(H_SYNC + H_BACK + H_VALID - 1);
  localparam logic [9:0] V_START   = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_END     = 10'(V_SYNC + V_BACK + V_VALID);

  logic [9:0] cnt_h;
  logic [9:0] cnt_v;
  logic [9:0] cnt_h_nxt;
  logic [9:0] cnt_v_nxt;
  logic       frame_end;
  logic       h_active;
  logic       v_active;
  logic       h_req;
  logic       pix_req;

  // Next-state logic: the counter pair is the whole state machine.
  always_comb begin
    cnt_h_nxt = cnt_h + 10'd1;
    cnt_v_nxt = cnt_v;
    frame_end = 1'b0;
    if (cnt_h == H_LAST) begin
      cnt_h_nxt = '0;
      if (cnt_v == V_LAST) begin
        cnt_v_nxt = '0;
        frame_end = 1'b1;
      end else begin
        cnt_v_nxt = cnt_v + 10'd1;
      end
    end
  end

  // frame_start and the shadows are all loaded on the last clock of a frame,
  // so they change together with the counter wrap to (0,0). Right after reset
  // the counters already sit at (0,0) but no frame has ended, hence no pulse.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h       <= '0;
      cnt_v       <= '0;
      frame_start <= 1'b0;
      status      <= '0;
      num         <= '0;
    end else begin
      cnt_h       <= cnt_h_nxt;
      cnt_v       <= cnt_v_nxt;
      frame_start <= frame_end;
      if (frame_end) begin
        status <= status_in;
        num    <= num_in;
      end
    end
  end

  // Decode. The request window runs one clock ahead of the active window so
  // the generator's output register delivers the pixel exactly on time. The
  // lower bound of the request window also keeps the subtraction from
  // underflowing into pix_x/pix_y.
  always_comb begin
    hsync     = (cnt_h < H_SYNC_W) ? SYNC_POL : ~SYNC_POL;
    vsync     = (cnt_v < V_SYNC_W) ? SYNC_POL : ~SYNC_POL;
    h_active  = (cnt_h >= H_START) && (cnt_h < H_END);
    v_active  = (cnt_v >= V_START) && (cnt_v < V_END);
    h_req     = (cnt_h >= H_REQ_BEG) && (cnt_h < H_REQ_END);
    rgb_valid = h_active && v_active;
    pix_req   = h_req && v_active;
    pix_x     = pix_req ? (cnt_h - H_REQ_BEG) : 10'h3FF;
    pix_y     = pix_req ? (cnt_v - V_START) : 10'h3FF;
    rgb       = rgb_valid ? pix_data : 12'h000;
  end

endmodule

// File: tb/tb_vga_ctrl.sv
// tb/tb_vga_ctrl.sv - self-checking bench for vga_ctrl (full-size line checks plus a scaled instance for frame-level checks)
module tb_vga_ctrl;

  logic vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic       rst_a, rst_b;
  logic [6:0] status_in;
  logic [3:0] num_in;

  // Full-size instance
  logic [11:0] pix_data_a, rgb_a;
  logic [9:0]  pix_x_a, pix_y_a;
  logic [6:0]  status_a;
  logic [3:0]  num_a;
  logic        hsync_a, vsync_a, rgb_valid_a, frame_start_a;

  // Scaled instance: line 17 clocks, frame 12 lines (204 clocks), positive sync
  logic [11:0] pix_data_b, rgb_b;
  logic [9:0]  pix_x_b, pix_y_b;
  logic [6:0]  status_b;
  logic [3:0]  num_b;
  logic        hsync_b, vsync_b, rgb_valid_b, frame_start_b;

  vga_ctrl dut_a (
    .vga_clk(vga_clk), .sys_rst_n(rst_a), .pix_data(pix_data_a),
    .status_in(status_in), .num_in(num_in), .pix_x(pix_x_a), .pix_y(pix_y_a),
    .status(status_a), .num(num_a), .hsync(hsync_a), .vsync(vsync_a),
    .rgb(rgb_a), .rgb_valid(rgb_valid_a), .frame_start(frame_start_a)
  );

  vga_ctrl #(
    .H_SYNC(4), .H_BACK(3), .H_VALID(8), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(3), .V_VALID(5), .V_FRONT(2), .SYNC_POL(1'b1)
  ) dut_b (
    .vga_clk(vga_clk), .sys_rst_n(rst_b), .pix_data(pix_data_b),
    .status_in(status_in), .num_in(num_in), .pix_x(pix_x_b), .pix_y(pix_y_b),
    .status(status_b), .num(num_b), .hsync(hsync_b), .vsync(vsync_b),
    .rgb(rgb_b), .rgb_valid(rgb_valid_b), .frame_start(frame_start_b)
  );

  // Registered pixel generator model: returns {2'b0, pix_x}
  always_ff @(posedge vga_clk) begin
    pix_data_a <= {2'b00, pix_x_a};
    pix_data_b <= {2'b00, pix_x_b};
  end

  int checks = 0;
  int failures = 0;
  logic [11:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected decode from the model position; requests push the pixel the
  // generator will return, active cycles pop it and compare against rgb.
  task automatic check_timing(input string who, input int mh, input int mv,
                              input int hs, input int hb, input int hv,
                              input int vs, input int vb, input int vv, input logic pol,
                              input logic o_hs, input logic o_vs, input logic o_rv,
                              input logic [9:0] o_px, input logic [9:0] o_py,
                              input logic [11:0] o_rgb);
    int hstart, vstart;
    logic e_hs, e_vs, e_rv, e_req, v_in;
    logic [9:0] e_px, e_py;
    logic [31:0] e_rgb;
    hstart = hs + hb;
    vstart = vs + vb;
    e_hs  = (mh < hs) ? pol : ~pol;
    e_vs  = (mv < vs) ? pol : ~pol;
    v_in  = (mv >= vstart) && (mv < vstart + vv);
    e_rv  = (mh >= hstart) && (mh < hstart + hv) && v_in;
    e_req = (mh >= hstart - 1) && (mh < hstart + hv - 1) && v_in;
    e_px  = e_req ? 10'(mh - (hstart - 1)) : 10'h3FF;
    e_py  = e_req ? 10'(mv - vstart) : 10'h3FF;
    chk($sformatf("%s_sync h=%0d v=%0d", who, mh, mv), {o_hs, o_vs}, {e_hs, e_vs});
    chk($sformatf("%s_rgb_valid h=%0d v=%0d", who, mh, mv), o_rv, e_rv);
    chk($sformatf("%s_pix_x h=%0d v=%0d", who, mh, mv), o_px, e_px);
    chk($sformatf("%s_pix_y h=%0d v=%0d", who, mh, mv), o_py, e_py);
    if (e_rv) e_rgb = (sb_q.size() > 0) ? {20'h0, sb_q.pop_front()} : 32'hDEAD0000;
    else      e_rgb = 32'h0;
    chk($sformatf("%s_rgb h=%0d v=%0d", who, mh, mv), o_rgb, e_rgb);
    if (e_req) sb_q.push_back({2'b00, e_px});
  endtask

  task automatic check_reset(input string who, input logic pol,
                             input logic o_hs, input logic o_vs, input logic o_rv,
                             input logic [9:0] o_px, input logic [9:0] o_py, input logic [11:0] o_rgb,
                             input logic [6:0] o_st, input logic [3:0] o_nm, input logic o_fs);
    chk({who, "_rst_sync"}, {o_hs, o_vs}, {pol, pol});
    chk({who, "_rst_rgb_valid"}, o_rv, 0);
    chk({who, "_rst_rgb"}, o_rgb, 0);
    chk({who, "_rst_pix"}, {o_px, o_py}, 20'hFFFFF);
    chk({who, "_rst_shadow"}, {o_st, o_nm}, 0);
    chk({who, "_rst_frame_start"}, o_fs, 0);
  endtask

  // Scaled-instance model state
  int bh, bv, bframe, bcyc, blast_fs, bvs_cnt;
  logic [6:0] bst;
  logic [3:0] bnum;

  task automatic reset_model_b();
    bh = 0; bv = 0; bframe = 0; bcyc = 0; blast_fs = 0; bvs_cnt = 0;
    bst = '0; bnum = '0;
    sb_q.delete();
  endtask

  task automatic step_b();
    check_timing("b", bh, bv, 4, 3, 8, 2, 3, 5, 1'b1, hsync_b, vsync_b, rgb_valid_b,
                 pix_x_b, pix_y_b, rgb_b);
    chk($sformatf("b_frame_start h=%0d v=%0d f=%0d", bh, bv, bframe), frame_start_b,
        (bh == 0 && bv == 0 && bframe > 0));
    chk($sformatf("b_status h=%0d v=%0d f=%0d", bh, bv, bframe), status_b, bst);
    chk($sformatf("b_num h=%0d v=%0d f=%0d", bh, bv, bframe), num_b, bnum);
    if (vsync_b === 1'b1) bvs_cnt++;
    if (frame_start_b === 1'b1) begin
      chk("b_frame_period", bcyc - blast_fs, 204);
      blast_fs = bcyc;
    end
  endtask

  // Called after this cycle's stimulus: the shadows capture whatever the
  // inputs hold on the last clock of the frame.
  task automatic adv_b();
    if (bh == 16 && bv == 11) begin
      chk($sformatf("b_vsync_len f=%0d", bframe), bvs_cnt, 34);
      bvs_cnt = 0;
      bst  = status_in;
      bnum = num_in;
    end
    @(negedge vga_clk);
    bcyc++;
    bh++;
    if (bh == 17) begin
      bh = 0;
      if (bv == 11) begin
        bv = 0;
        bframe++;
      end else begin
        bv++;
      end
    end
  endtask

  initial begin
    int ah, av;
    rst_a = 1'b0;
    rst_b = 1'b0;
    status_in = '0;
    num_in = '0;

    // Full-size instance: reset, then lines 0..1 and 34..35 cycle by cycle
    repeat (5) @(negedge vga_clk);
    check_reset("a", 1'b0, hsync_a, vsync_a, rgb_valid_a, pix_x_a, pix_y_a, rgb_a,
                status_a, num_a, frame_start_a);
    rst_a = 1'b1;
    ah = 0;
    av = 0;
    for (int c = 0; c < 36 * 800; c++) begin
      if (av <= 1 || av >= 34) begin
        check_timing("a", ah, av, 96, 48, 640, 2, 33, 480, 1'b0, hsync_a, vsync_a,
                     rgb_valid_a, pix_x_a, pix_y_a, rgb_a);
        chk($sformatf("a_frame_start h=%0d v=%0d", ah, av), frame_start_a, 0);
      end
      @(negedge vga_clk);
      ah++;
      if (ah == 800) begin
        ah = 0;
        av++;
      end
    end
    chk("a_sb_drain", sb_q.size(), 0);

    // Scaled instance: reset, shadows, frame period, vertical bounds
    check_reset("b", 1'b1, hsync_b, vsync_b, rgb_valid_b, pix_x_b, pix_y_b, rgb_b,
                status_b, num_b, frame_start_b);
    rst_b = 1'b1;
    reset_model_b();
    for (int c = 0; c < 3 * 204; c++) begin
      step_b();
      if (bframe == 0 && bv == 6 && bh == 9) begin
        num_in = 4'd2;
        status_in = 7'h55;
      end
      if (bframe == 1 && bv == 7 && bh == 10) begin
        status_in = 7'h2A;
        num_in = 4'd5;
      end
      if (bframe == 2 && bv == 3 && bh == 8) break;
      adv_b();
    end
    chk("b_mid_reset_reached", {bframe[7:0], bv[7:0], bh[7:0]}, {8'd2, 8'd3, 8'd8});

    // Asynchronous reset between edges: outputs must drop before the next edge
    #2 rst_b = 1'b0;
    #1;
    check_reset("b_mid", 1'b1, hsync_b, vsync_b, rgb_valid_b, pix_x_b, pix_y_b, rgb_b,
                status_b, num_b, frame_start_b);
    repeat (3) @(negedge vga_clk);
    rst_b = 1'b1;
    reset_model_b();
    for (int c = 0; c < 204 + 40; c++) begin
      step_b();
      adv_b();
    end
    chk("b_fs_after_reset", blast_fs, 204);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
